// File: rtl/rsc_step_pkg.sv
// Shared types and sizing constants for the single-step key generator and
// future asynchronous-input helpers.
package rsc_step_pkg;

   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_PRESS_CHK   = 2'd1,
      S_PRESSED     = 2'd2,
      S_RELEASE_CHK = 2'd3
   } step_state_t;

   localparam int DEBOUNCE_DEFAULT = 500000;    // 10 ms at 50 MHz
   localparam int AUTO_DIV_DEFAULT = 25000000;  // 0.5 s at 50 MHz
   localparam int CNT_W            = 20;
   localparam int DIV_W            = 25;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reset value is a parameter
// so idle-high (active-low) inputs come out of reset as "released".
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/key_step_gen.sv
// Debounced pushbutton to single-cycle CPU step enable, with step counter.
// Define STEP_AUTORUN_EN to add a free-running auto-step divider gated by run_mode.
module key_step_gen
   import rsc_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int AUTO_DIV        = AUTO_DIV_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_n,
   input  logic        run_mode,
   output logic        step,
   output logic        key_level,
   output logic [15:0] step_count
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             key_s;
   logic             pressed_s;
   step_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             manual_step;
   logic             auto_step;

   // key_n idles high, so both flops reset to 1 to look released.
   sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_key_sync (
      .clk   (clk),
      .reset (reset),
      .d     (key_n),
      .q     (key_s)
   );

   assign pressed_s = ~key_s;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      manual_step = 1'b0;
      case (state)
         S_IDLE: begin
            if (pressed_s) begin
               state_nxt = S_PRESS_CHK;
               cnt_nxt   = '0;
            end
         end
         S_PRESS_CHK: begin
            if (!pressed_s) begin
               state_nxt = S_IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nxt   = S_PRESSED;
               manual_step = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_PRESSED: begin
            if (!pressed_s) begin
               state_nxt = S_RELEASE_CHK;
               cnt_nxt   = '0;
            end
         end
         S_RELEASE_CHK: begin
            // a bounce back to pressed is the same press, so no step here
            if (pressed_s) begin
               state_nxt = S_PRESSED;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef STEP_AUTORUN_EN
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

   logic [DIV_W-1:0] div;
   logic             div_en;

   assign div_en    = run_mode && (state == S_IDLE);
   // auto steps only happen in IDLE, where a manual step cannot fire
   assign auto_step = div_en && (div == DIV_LAST) && !manual_step;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          div <= '0;
      else if (!div_en || div == DIV_LAST) div <= '0;
      else                                div <= div + 1'b1;
   end
`else
   logic unused_run_mode;

   assign unused_run_mode = run_mode;
   assign auto_step       = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         step       <= 1'b0;
         key_level  <= 1'b0;
         step_count <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         step      <= manual_step | auto_step;
         key_level <= (state_nxt == S_PRESSED) || (state_nxt == S_RELEASE_CHK);
         if (step) step_count <= step_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_key_step_gen.sv
// Directed self-checking bench for key_step_gen with DEBOUNCE_CYCLES=4, AUTO_DIV=10.
module tb_key_step_gen;

   logic        clk;
   logic        reset;
   logic        key_n;
   logic        run_mode;
   logic        step;
   logic        key_level;
   logic [15:0] step_count;

   int n_tests = 0;
   int n_fail  = 0;

   key_step_gen #(.DEBOUNCE_CYCLES(4), .AUTO_DIV(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .key_n      (key_n),
      .run_mode   (run_mode),
      .step       (step),
      .key_level  (key_level),
      .step_count (step_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      key_n    = 1'b1;
      run_mode = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      key_n    = 1'b1;
      run_mode = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_step",       32'(step),       32'd0);
      chk("rst_key_level",  32'(key_level),  32'd0);
      chk("rst_step_count", 32'(step_count), 32'd0);
      reset = 1'b0;

      // Held press: step only after edge e0+6, key_level from the same edge
      @(negedge clk);
      key_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("press_step_e%0d", i),  32'(step),      32'(i == 6));
         chk($sformatf("press_level_e%0d", i), 32'(key_level), 32'(i >= 6));
      end
      chk("press_count", 32'(step_count), 32'd1);

      // Keep holding: no auto-repeat from the button
      for (int i = 0; i < 92; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("hold_step_%0d", i), 32'(step), 32'd0);
      end
      chk("hold_count", 32'(step_count), 32'd1);

      // Bounced release: high, low, then high for good
      key_n = 1'b1;
      @(negedge clk);
      chk("bounce_level_a", 32'(key_level), 32'd1);
      key_n = 1'b0;
      @(negedge clk);
      chk("bounce_level_b", 32'(key_level), 32'd1);
      key_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("release_level_r%0d", i), 32'(key_level), 32'(i < 6));
         chk($sformatf("release_step_r%0d", i),  32'(step),      32'd0);
      end
      chk("release_count", 32'(step_count), 32'd1);

      // 3-cycle glitch
      do_reset();
      @(negedge clk);
      key_n = 1'b0;
      repeat (3) @(negedge clk);
      key_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("glitch_step_%0d", i),  32'(step),      32'd0);
         chk($sformatf("glitch_level_%0d", i), 32'(key_level), 32'd0);
      end
      chk("glitch_count", 32'(step_count), 32'd0);

      // step_count wrap from 0xFFFF
      do_reset();
      @(negedge clk);
      force dut.step_count = 16'hFFFF;
      #1;
      release dut.step_count;
      @(negedge clk);
      key_n = 1'b0;
      repeat (8) @(negedge clk);
      chk("wrap_count", 32'(step_count), 32'h0000);
      key_n = 1'b1;

      // Reset during PRESS_CHK (cnt=2) with key still held
      do_reset();
      @(negedge clk);
      key_n = 1'b0;
      repeat (5) @(posedge clk);  // e0..e0+4, cnt reaches 2
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_step",  32'(step),      32'd0);
      chk("midrst_level", 32'(key_level), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("midrst_step_e%0d", i), 32'(step), 32'(i == 6));
      end
      chk("midrst_count", 32'(step_count), 32'd1);
      key_n = 1'b1;

      // Auto-run
      do_reset();
      @(negedge clk);
      run_mode = 1'b1;
      for (int i = 1; i <= 35; i++) begin
         @(posedge clk);
         @(negedge clk);
`ifdef STEP_AUTORUN_EN
         chk($sformatf("auto_step_c%0d", i), 32'(step), 32'(i % 10 == 0));
`else
         chk($sformatf("auto_step_c%0d", i), 32'(step), 32'd0);
`endif
      end
      run_mode = 1'b0;
      @(negedge clk);
`ifdef STEP_AUTORUN_EN
      chk("auto_count", 32'(step_count), 32'd3);
`else
      chk("auto_count", 32'(step_count), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
